// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter: accepts a WIDTH-bit word on load/ready,
// shifts it out MSB first with a valid strobe, then holds GAP idle cycles of zeros.
module serial_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int GAP   = 2,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             done,
   output logic [CNT_W-1:0] frame_count
);

   localparam int BCW = $clog2(WIDTH);
   localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
   localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] shreg_q,  shreg_d;
   logic [BCW-1:0]   bitcnt_q, bitcnt_d;
   logic [GW-1:0]    gapcnt_q, gapcnt_d;
   logic [CNT_W-1:0] count_q,  count_d;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      count_d  = count_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               shreg_d  = data_in;
               bitcnt_d = BIT_LAST;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q - BCW'(1);
            // Last bit is on the line this cycle: the frame completes at this edge.
            if (bitcnt_q == '0) begin
               count_d = count_q + CNT_W'(1);
               if (GAP > 0) begin
                  state_d  = S_GAP;
                  gapcnt_d = GAP_LOAD;
               end else begin
                  state_d  = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gapcnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gapcnt_d = gapcnt_q - GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         count_q  <= count_d;
      end
   end

   // Outputs decode registered state only; load/data_in never reach them combinationally.
   assign ready       = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_SHIFT);
   assign out         = out_valid & shreg_q[WIDTH-1];
   assign done        = out_valid && (bitcnt_q == '0);
   assign frame_count = count_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench: stimulus queues expected bits/counts, monitors pop and compare
// whenever a DUT presents out_valid or done.
module tb_serial_pattern_tx;
   localparam int W = 8;
   localparam int G = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, load;
   logic [7:0] data_in;
   logic       ready, out, out_valid, done;
   logic [7:0] frame_count;

   logic       rst2, load2;
   logic [7:0] data2;
   logic       ready2, out2, ov2, done2;
   logic [1:0] fc2;

   serial_pattern_tx #(.WIDTH(W), .GAP(G), .CNT_W(8)) dut (
      .clock(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready),
      .out(out), .out_valid(out_valid), .done(done), .frame_count(frame_count));

   serial_pattern_tx #(.WIDTH(W), .GAP(0), .CNT_W(2)) dut2 (
      .clock(clk), .rst(rst2), .data_in(data2), .load(load2), .ready(ready2),
      .out(out2), .out_valid(ov2), .done(done2), .frame_count(fc2));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_seen = 0;
   int acc_cyc  = 0;
   logic [7:0] model_cnt = 8'd0;
   logic [1:0] model_cnt2 = 2'd0;

   bit         exp_bits[$];
   logic [7:0] exp_cnt[$];
   bit         exp_bits2[$];
   logic [1:0] exp_cnt2[$];
   bit         cnt_pending  = 1'b0;
   bit         cnt_pending2 = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor for the default-parameter DUT.
   initial begin : mon1
      int idx;
      logic [7:0] cnt_req;
      idx = 0;
      cnt_req = '0;
      forever begin
         @(negedge clk);
         if (cnt_pending) begin
            check("frame_count", frame_count, cnt_req);
            cnt_pending = 1'b0;
         end
         if (out_valid) begin
            if (exp_bits.size() == 0) check("unexpected_bit", 1, 0);
            else check("out_bit", out, exp_bits.pop_front());
            if (done) begin
               done_seen++;
               check("done_pos", idx, W - 1);
               if (exp_cnt.size() == 0) check("unexpected_done", 1, 0);
               else begin
                  cnt_req = exp_cnt.pop_front();
                  cnt_pending = 1'b1;
               end
            end
            idx++;
         end else begin
            if (done) check("done_outside_frame", done, 0);
            idx = 0;
         end
      end
   end

   // Monitor for the GAP=0, CNT_W=2 DUT.
   initial begin : mon2
      int idx;
      logic [1:0] cnt_req;
      idx = 0;
      cnt_req = '0;
      forever begin
         @(negedge clk);
         if (cnt_pending2) begin
            check("frame_count2", fc2, cnt_req);
            cnt_pending2 = 1'b0;
         end
         if (ov2) begin
            if (exp_bits2.size() == 0) check("unexpected_bit2", 1, 0);
            else check("out_bit2", out2, exp_bits2.pop_front());
            if (done2) begin
               check("done_pos2", idx, W - 1);
               if (exp_cnt2.size() == 0) check("unexpected_done2", 1, 0);
               else begin
                  cnt_req = exp_cnt2.pop_front();
                  cnt_pending2 = 1'b1;
               end
            end
            idx++;
         end else begin
            if (done2) check("done_outside_frame2", done2, 0);
            idx = 0;
         end
      end
   end

   // Called at a negedge; waits for ready, presents the word across one accept edge.
   task automatic issue(input logic [7:0] w, input bit hold);
      int n = 0;
      while (!ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      data_in = w;
      load    = 1'b1;
      for (int i = W - 1; i >= 0; i--) exp_bits.push_back(w[i]);
      model_cnt = model_cnt + 8'd1;
      exp_cnt.push_back(model_cnt);
      acc_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      if (!hold) load = 1'b0;
      data_in = ~w;
   endtask

   initial begin : stim
      int n;
      int t0;
      int ds;
      int acc2;
      int last2;
      rst = 1'b1; load = 1'b0; data_in = 8'h00;
      rst2 = 1'b1; load2 = 1'b0; data2 = 8'h81;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; rst2 = 1'b0;
      check("reset_ready", ready, 1);
      check("reset_out", out, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_done", done, 0);
      check("reset_frame_count", frame_count, 0);

      // Single frame 0xB4, ready returns on the 11th cycle after accept.
      issue(8'hB4, 1'b0);
      n = 0;
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ready_return_cycles", n, W + G);
      check("count_after_single", frame_count, 1);

      // Back-to-back with load held high.
      issue(8'hA5, 1'b1);
      t0 = acc_cyc;
      issue(8'h3C, 1'b1);
      check("b2b_period", acc_cyc - t0, W + G + 1);
      load = 1'b0;

      // Load while busy must be ignored until ready returns.
      issue(8'hF0, 1'b0);
      repeat (2) @(negedge clk);
      load = 1'b1;
      data_in = 8'h0F;
      issue(8'h0F, 1'b0);

      // Reset while the 3rd bit of 0xFF is on the line.
      issue(8'hFF, 1'b0);
      ds = done_seen;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_bits.delete();
      exp_cnt.delete();
      model_cnt = 8'd0;
      check("abort_out", out, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_ready", ready, 1);
      check("abort_frame_count", frame_count, 0);
      check("abort_no_done", done_seen, ds);
      issue(8'h5A, 1'b0);

      // GAP=0, CNT_W=2: five frames of 0x81 with load held, count wraps.
      load2 = 1'b1;
      acc2 = 0;
      last2 = 0;
      n = 0;
      while (acc2 < 5 && n < 200) begin
         if (ready2) begin
            for (int i = W - 1; i >= 0; i--) exp_bits2.push_back(data2[i]);
            model_cnt2 = model_cnt2 + 2'd1;
            exp_cnt2.push_back(model_cnt2);
            acc2++;
            if (acc2 > 1) check("period_gap0", cyc - last2, W + 1);
            last2 = cyc;
            @(posedge clk);
            @(negedge clk);
            if (acc2 == 5) load2 = 1'b0;
            check("ready2_low_after_accept", ready2, 0);
         end else begin
            @(negedge clk);
         end
         n++;
      end
      check("gap0_frames_accepted", acc2, 5);

      n = 0;
      while ((exp_bits.size() != 0 || exp_cnt.size() != 0 || exp_bits2.size() != 0 ||
              exp_cnt2.size() != 0 || cnt_pending || cnt_pending2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("scoreboard_drained",
            exp_bits.size() + exp_cnt.size() + exp_bits2.size() + exp_cnt2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
